perceptron_issue_ctrl: RTL and testbench

Initiator side of the Perceptron core interface. It accepts operand bundles (x[N], w[N], b) on a valid/ready stream and launches them into the fixed-latency, non-stallable Perceptron pipeline. It tracks in-flight launches with a valid shift register and captures each pe_y into a result FIFO. Results are returned on a valid/ready stream tagged with a sequence number. Credit-based admission guarantees no result is ever dropped.

---
 rtl/perceptron_pkg.sv | 19 +
 rtl/perceptron_issue_ctrl_result_fifo.sv | 75 +++++++
 rtl/perceptron_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_perceptron_issue_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared constants and types for the Perceptron core interface.
// Result entries pair the launch tag with the core output.
package perceptron_pkg;

  localparam int N            = 4;
  localparam int DATA_WIDTH   = 8;
  localparam int LATENCY      = 3;
  localparam int RESULT_DEPTH = 8;
  localparam int SEQ_W        = 8;

  typedef logic signed [DATA_WIDTH-1:0] data_t;
  typedef data_t [N-1:0]                vec_t;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    data_t            y;
  } result_t;

endpackage

// File: rtl/perceptron_issue_ctrl_result_fifo.sv
// Synchronous first-word-fall-through FIFO for tagged core results.
// The head reads as zero while empty so the output bus is clean after reset.
module result_fifo
  import perceptron_pkg::*;
#(
  parameter int  DEPTH = RESULT_DEPTH,
  parameter type T     = result_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  T                           wr_data,
  input  logic                       rd_en,
  output T                           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(wr_en && !rd_en && count_q == CNT_W'(DEPTH)));
      assert (!(rd_en && count_q == '0));
    end
  end
`endif

endmodule

// File: rtl/perceptron_issue_ctrl.sv
// Initiator for the fixed-latency Perceptron pipeline: launches operand bundles,
// tracks them with a valid/tag shift register and queues tagged results.
module perceptron_issue_ctrl
  import perceptron_pkg::*;
#(
  parameter int N            = perceptron_pkg::N,
  parameter int DATA_WIDTH   = perceptron_pkg::DATA_WIDTH,
  parameter int LATENCY      = perceptron_pkg::LATENCY,
  parameter int RESULT_DEPTH = perceptron_pkg::RESULT_DEPTH,
  parameter int SEQ_W        = perceptron_pkg::SEQ_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N-1:0][DATA_WIDTH-1:0]  in_x,
  input  logic [N-1:0][DATA_WIDTH-1:0]  in_w,
  input  logic signed [DATA_WIDTH-1:0]  in_b,
  output logic [N-1:0][DATA_WIDTH-1:0]  pe_x,
  output logic [N-1:0][DATA_WIDTH-1:0]  pe_w,
  output logic signed [DATA_WIDTH-1:0]  pe_b,
  input  logic signed [DATA_WIDTH-1:0]  pe_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_WIDTH-1:0]  out_y,
  output logic [SEQ_W-1:0]              out_seq,
  output logic                          busy
);

  localparam int CNT_W = $clog2(RESULT_DEPTH + 1);

  typedef struct packed {
    logic [SEQ_W-1:0]             seq;
    logic signed [DATA_WIDTH-1:0] y;
  } res_t;

  logic [N-1:0][DATA_WIDTH-1:0] pe_x_q, pe_x_d;
  logic [N-1:0][DATA_WIDTH-1:0] pe_w_q, pe_w_d;
  logic signed [DATA_WIDTH-1:0] pe_b_q, pe_b_d;
  logic [SEQ_W-1:0]             seq_q, seq_d;
  logic [LATENCY:0]             vld_q, vld_d;
  logic [SEQ_W-1:0]             tag_q [LATENCY+1];
  logic [SEQ_W-1:0]             tag_d [LATENCY+1];

  logic             accept;
  logic             pop;
  logic [CNT_W-1:0] fifo_count;
  res_t             fifo_wr_data;
  res_t             fifo_head;
  int               inflight;
  int               credit_used;

  // Credits come only from registered state so in_ready never depends on
  // in_valid or out_ready in the same cycle.
  always_comb begin
    inflight = 0;
    for (int i = 0; i <= LATENCY; i++) begin
      inflight = inflight + int'(vld_q[i]);
    end
    credit_used = inflight + int'(fifo_count);
  end

  assign in_ready = (credit_used < RESULT_DEPTH);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    pe_x_d = pe_x_q;
    pe_w_d = pe_w_q;
    pe_b_d = pe_b_q;
    seq_d  = seq_q;
    vld_d  = vld_q;
    tag_d  = tag_q;
    if (accept) begin
      pe_x_d = in_x;
      pe_w_d = in_w;
      pe_b_d = in_b;
      seq_d  = seq_q + SEQ_W'(1);
    end
    vld_d[0] = accept;
    tag_d[0] = seq_q;
    for (int i = 1; i <= LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_x_q <= '0;
      pe_w_q <= '0;
      pe_b_q <= '0;
      seq_q  <= '0;
      vld_q  <= '0;
      tag_q  <= '{default: '0};
    end else begin
      pe_x_q <= pe_x_d;
      pe_w_q <= pe_w_d;
      pe_b_q <= pe_b_d;
      seq_q  <= seq_d;
      vld_q  <= vld_d;
      tag_q  <= tag_d;
    end
  end

  // The last stage lines up with the edge after pe_y becomes valid.
  assign fifo_wr_data = '{seq: tag_q[LATENCY], y: pe_y};

  result_fifo #(
    .DEPTH (RESULT_DEPTH),
    .T     (res_t)
  ) u_result_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (vld_q[LATENCY]),
    .wr_data  (fifo_wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_head),
    .rd_valid (out_valid),
    .count    (fifo_count)
  );

  assign pe_x    = pe_x_q;
  assign pe_w    = pe_w_q;
  assign pe_b    = pe_b_q;
  assign out_y   = fifo_head.y;
  assign out_seq = fifo_head.seq;
  assign busy    = (|vld_q) || (fifo_count != '0);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (credit_used <= RESULT_DEPTH);
    end
  end
`endif

endmodule

// File: tb/tb_perceptron_issue_ctrl.sv
// Directed bench for perceptron_issue_ctrl with a delay-line stand-in for the core.
module tb_perceptron_issue_ctrl;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int LAT = 3;
  localparam int SW  = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0][DW-1:0]  in_x;
  logic [N-1:0][DW-1:0]  in_w;
  logic signed [DW-1:0]  in_b;
  logic [N-1:0][DW-1:0]  pe_x;
  logic [N-1:0][DW-1:0]  pe_w;
  logic signed [DW-1:0]  pe_b;
  logic signed [DW-1:0]  pe_y;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [DW-1:0]  out_y;
  logic [SW-1:0]         out_seq;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  logic [SW+DW-1:0] exp_q [$];
  logic [SW-1:0]    seq_m;

  always #5 clk = ~clk;

  // Core stand-in: pe_y is pe_b sampled LAT edges earlier.
  logic signed [DW-1:0] core_d [LAT];
  initial foreach (core_d[i]) core_d[i] = '0;
  always @(posedge clk) begin
    core_d[0] <= pe_b;
    for (int i = 1; i < LAT; i++) core_d[i] <= core_d[i-1];
  end
  assign pe_y = core_d[LAT-1];

  perceptron_issue_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_b      (in_b),
    .pe_x      (pe_x),
    .pe_w      (pe_w),
    .pe_b      (pe_b),
    .pe_y      (pe_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_seq   (out_seq),
    .busy      (busy)
  );

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    seq_m = '0;
  endtask

  // Records handshakes seen before the edge, then advances one clock.
  task automatic cycle(output bit acc, output bit pop,
                       output logic [SW-1:0] pseq, output logic signed [DW-1:0] py);
    acc  = in_valid && in_ready;
    pop  = out_valid && out_ready;
    pseq = out_seq;
    py   = out_y;
    if (acc) begin
      exp_q.push_back({seq_m, in_b});
      seq_m = seq_m + 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pe_x !== '0 || pe_w !== '0 || pe_b !== '0) begin
      errors++; $display("FAIL reset_pe pe_x=%h pe_w=%h pe_b=%0d required 0", pe_x, pe_w, pe_b);
    end
    checks++;
    if (out_valid !== 1'b0 || out_y !== '0 || out_seq !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_out out_valid=%b out_y=%0d out_seq=%0d busy=%b required 0",
                         out_valid, out_y, out_seq, busy);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready in_ready=%b required 1", in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    bit acc, pop; logic [SW-1:0] ps; logic signed [DW-1:0] py;
    do_reset();
    for (int i = 0; i < 5; i++) cycle(acc, pop, ps, py);
    in_x = {8'd4, 8'd3, 8'd2, 8'd1};
    in_w = {8'hF0, 8'h10, 8'h7F, 8'h80};
    in_b = 8'sd5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cycle(acc, pop, ps, py);
    in_valid = 1'b0;
    checks++;
    if (acc !== 1'b1) begin
      errors++; $display("FAIL single_accept accepted=%b required 1", acc);
    end
    checks++;
    if (pe_x !== 32'h04030201 || pe_w !== 32'hF0107F80 || pe_b !== 8'sd5) begin
      errors++; $display("FAIL single_pe pe_x=%h pe_w=%h pe_b=%0d required 04030201 f0107f80 5",
                         pe_x, pe_w, pe_b);
    end
    for (int k = 1; k <= 4; k++) begin
      cycle(acc, pop, ps, py);
      checks++;
      if (out_valid !== (k == 4)) begin
        errors++; $display("FAIL single_latency edge+%0d out_valid=%b required %b", k, out_valid, k == 4);
      end
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL single_busy busy=%b required 1", busy);
        end
      end
    end
    checks++;
    if (out_y !== 8'sd5 || out_seq !== 8'd0) begin
      errors++; $display("FAIL single_result out_y=%0d out_seq=%0d required 5/0", out_y, out_seq);
    end
    cycle(acc, pop, ps, py);
    checks++;
    if (pop !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_drain pop=%b out_valid=%b busy=%b required 1/0/0", pop, out_valid, busy);
    end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    bit acc, pop; logic [SW-1:0] ps; logic signed [DW-1:0] py;
    logic [SW+DW-1:0] e;
    int sent = 0, got = 0, drops = 0, first = -1, last = -1;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 60 && got < 20; c++) begin
      in_valid = (sent < 20);
      in_b = DW'(sent + 1);
      if (in_valid && !in_ready) drops++;
      cycle(acc, pop, ps, py);
      if (acc) sent++;
      if (pop) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if ({ps, py} !== e) begin
          errors++; $display("FAIL b2b_data seq=%0d y=%0d required seq=%0d y=%0d",
                             ps, py, e[SW+DW-1:DW], $signed(e[DW-1:0]));
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (drops != 0 || got != 20 || last - first != 19) begin
      errors++; $display("FAIL b2b_throughput ready_drops=%0d results=%0d span=%0d required 0/20/19",
                         drops, got, last - first);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_stall();
    bit acc, pop; logic [SW-1:0] ps; logic signed [DW-1:0] py;
    logic [SW+DW-1:0] e;
    int sent = 0, got = 0;
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      in_valid = 1'b1;
      in_b = DW'(sent - 3);
      cycle(acc, pop, ps, py);
      if (acc) sent++;
      if (c == 6) begin
        checks++;
        if (out_valid !== 1'b1 || out_y !== -8'sd3 || out_seq !== 8'd0) begin
          errors++; $display("FAIL stall_head_early out_valid=%b out_y=%0d out_seq=%0d required 1/-3/0",
                             out_valid, out_y, out_seq);
        end
      end
    end
    checks++;
    if (sent != 8 || in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_credit accepted=%0d in_ready=%b required 8/0", sent, in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || out_y !== -8'sd3 || out_seq !== 8'd0) begin
      errors++; $display("FAIL stall_head_late out_valid=%b out_y=%0d out_seq=%0d required 1/-3/0",
                         out_valid, out_y, out_seq);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 8; c++) begin
      cycle(acc, pop, ps, py);
      if (pop) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if ({ps, py} !== e) begin
          errors++; $display("FAIL stall_drain seq=%0d y=%0d required seq=%0d y=%0d",
                             ps, py, e[SW+DW-1:DW], $signed(e[DW-1:0]));
        end
        got++;
        if (got == 1) begin
          checks++;
          if (in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_reassert in_ready=%b required 1", in_ready);
          end
        end
      end
    end
    checks++;
    if (got != 8 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_count results=%0d busy=%b required 8/0", got, busy);
    end
    $display("test_stall done");
  endtask

  task automatic test_wrap();
    bit acc, pop; logic [SW-1:0] ps; logic signed [DW-1:0] py;
    logic [SW+DW-1:0] e;
    int sent = 0, got = 0, wraps = 0;
    logic [SW-1:0] prev = '0;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 400 && got < 300; c++) begin
      in_valid = (sent < 300);
      in_b = DW'(sent * 7);
      cycle(acc, pop, ps, py);
      if (acc) sent++;
      if (pop) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if ({ps, py} !== e) begin
          errors++; $display("FAIL wrap_data seq=%0d y=%0d required seq=%0d y=%0d",
                             ps, py, e[SW+DW-1:DW], $signed(e[DW-1:0]));
        end
        if (got > 0 && prev == 8'd255 && ps == 8'd0) wraps++;
        prev = ps;
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 300 || wraps != 1) begin
      errors++; $display("FAIL wrap_count results=%0d wraps=%0d required 300/1", got, wraps);
    end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    bit acc, pop; logic [SW-1:0] ps; logic signed [DW-1:0] py;
    int got = 0;
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_b = DW'(10 + c);
      cycle(acc, pop, ps, py);
    end
    in_valid = 1'b0;
    cycle(acc, pop, ps, py);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || out_y !== 8'sd10) begin
      errors++; $display("FAIL midrst_pre out_valid=%b busy=%b out_y=%0d required 1/1/10", out_valid, busy, out_y);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    seq_m = '0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_seq !== 8'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_post out_valid=%b busy=%b out_seq=%0d in_ready=%b required 0/0/0/1",
                         out_valid, busy, out_seq, in_ready);
    end
    in_valid = 1'b1;
    in_b = 8'sd7;
    out_ready = 1'b1;
    cycle(acc, pop, ps, py);
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cycle(acc, pop, ps, py);
      if (pop) begin
        checks++;
        if (ps !== 8'd0 || py !== 8'sd7) begin
          errors++; $display("FAIL midrst_result seq=%0d y=%0d required 0/7", ps, py);
        end
        got++;
      end
    end
    checks++;
    if (got != 1) begin
      errors++; $display("FAIL midrst_count results=%0d required 1", got);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    bit acc, pop; logic [SW-1:0] ps; logic signed [DW-1:0] py;
    logic [SW+DW-1:0] e;
    int sent = 0, got = 0;
    do_reset();
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      in_valid  = (sent < 1000) && ($urandom_range(1, 0) == 1);
      in_b      = DW'($urandom);
      in_x      = 32'($urandom);
      in_w      = 32'($urandom);
      out_ready = ($urandom_range(1, 0) == 1);
      cycle(acc, pop, ps, py);
      if (acc) sent++;
      if (pop) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if ({ps, py} !== e) begin
          errors++; $display("FAIL random_data seq=%0d y=%0d required seq=%0d y=%0d",
                             ps, py, e[SW+DW-1:DW], $signed(e[DW-1:0]));
        end
        got++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 1000 || exp_q.size() != 0) begin
      errors++; $display("FAIL random_count results=%0d pending=%0d required 1000/0", got, exp_q.size());
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = '0;
    in_w = '0;
    in_b = '0;
    seq_m = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
